seq_tx_1011: RTL and testbench

SEQ_TX_1011 -- requirements
Module: seq_tx_1011

---
 rtl/seq_tx_1011.sv | 130 +++++++++++++
 tb/tb_seq_tx_1011.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_tx_1011.sv
// Serial frame transmitter: sends sync 1011, then DATA_W payload bits MSB first,
// then GUARD idle zeros, and pulses frame_done_o on the first idle cycle after a frame.
module seq_tx_1011 #(
  parameter int DATA_W = 8,
  parameter int GUARD  = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int MAX_A = (DATA_W > 4) ? DATA_W : 4;
  localparam int MAX_L = (GUARD > MAX_A) ? GUARD : MAX_A;
  localparam int CNT_W = $clog2(MAX_L);

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GRD_LAST  = CNT_W'(GUARD - 1);

  // Bit i of this constant is the sync bit sent at counter position i.
  localparam logic [3:0] SYNC_PAT = 4'b1101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    PAYLOAD = 2'd2,
    GUARD_S = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;

  function automatic logic sync_bit(input logic [1:0] idx);
    sync_bit = SYNC_PAT[idx];
  endfunction

  // State, counter, shift register and output flops.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      shift_q <= {DATA_W{1'b0}};
      tx_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Next-state sequencing; tx is computed from the next state so the
  // registered line shows the first sync bit right after the accept edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    tx_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          state_d = SYNC;
          cnt_d   = CNT_ZERO;
          shift_d = data_i;
        end else begin
          state_d = IDLE;
        end
      end
      SYNC: begin
        if (cnt_q == SYNC_LAST) begin
          state_d = PAYLOAD;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PAYLOAD: begin
        if (cnt_q == PAY_LAST) begin
          state_d = GUARD_S;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GUARD_S: begin
        if (cnt_q == GRD_LAST) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // Payload leaves MSB first: emit the top bit and shift it out.
    case (state_d)
      SYNC:    tx_d = sync_bit(cnt_d[1:0]);
      PAYLOAD: begin
        tx_d    = shift_q[DATA_W-1];
        shift_d = shift_q << 1'b1;
      end
      default: tx_d = 1'b0;
    endcase
  end

  assign tx_o         = tx_q;
  assign frame_done_o = done_q;
  assign ready_o      = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_seq_tx_1011.sv
// Directed bench for seq_tx_1011: default instance (8/2) plus a 1/1 parameter
// corner instance, with a behavioral 1011 Moore detector on the default tx line.
module tb_seq_tx_1011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic       ready, tx, busy, fd;
  logic [0:0] d1;
  logic       valid1;
  logic       ready1, tx1, busy1, fd1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t1, t2;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  seq_tx_1011 #(.DATA_W(8), .GUARD(2)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(valid),
    .ready_o(ready), .tx_o(tx), .busy_o(busy), .frame_done_o(fd)
  );

  seq_tx_1011 #(.DATA_W(1), .GUARD(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(d1), .valid_i(valid1),
    .ready_o(ready1), .tx_o(tx1), .busy_o(busy1), .frame_done_o(fd1)
  );

  // Overlapping 1011 Moore detector fed by the serial line.
  localparam logic [2:0] D0 = 3'd0, D1 = 3'd1, D10 = 3'd2, D101 = 3'd3, D1011 = 3'd4;
  logic [2:0] det_q;
  logic       det;

  always @(posedge clk) begin
    if (!rst_n) det_q <= D0;
    else begin
      case (det_q)
        D0:      det_q <= tx ? D1    : D0;
        D1:      det_q <= tx ? D1    : D10;
        D10:     det_q <= tx ? D101  : D0;
        D101:    det_q <= tx ? D1011 : D10;
        D1011:   det_q <= tx ? D1    : D10;
        default: det_q <= D0;
      endcase
    end
  end
  assign det = (det_q == D1011);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in the first sync cycle; returns in the first IDLE cycle after the frame.
  task automatic frame14(input string tag, input logic [13:0] v);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("%s_tx%0d", tag, i), {31'd0, tx}, {31'd0, v[13-i]});
      chk($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, 32'd1);
      chk($sformatf("%s_fd%0d", tag, i), {31'd0, fd}, 32'd0);
      step();
    end
  endtask

  initial begin
    logic [5:0] v6;
    rst_n  = 1'b0;
    valid  = 1'b1;
    data   = 8'hA5;
    valid1 = 1'b0;
    d1     = 1'b1;
    step();
    step();
    chk("rst_tx",     {31'd0, tx},     32'd0);
    chk("rst_ready",  {31'd0, ready},  32'd1);
    chk("rst_busy",   {31'd0, busy},   32'd0);
    chk("rst_fd",     {31'd0, fd},     32'd0);
    chk("rst_ready1", {31'd0, ready1}, 32'd1);
    chk("rst_tx1",    {31'd0, tx1},    32'd0);

    // valid held through reset: accepted on the first edge with reset released
    rst_n = 1'b1;
    step();
    valid = 1'b0;
    data  = 8'h00;
    frame14("single", {4'b1011, 8'hA5, 2'b00});
    chk("single_fd",    {31'd0, fd},    32'd1);
    chk("single_ready", {31'd0, ready}, 32'd1);
    chk("single_busy",  {31'd0, busy},  32'd0);
    chk("single_idle_tx", {31'd0, tx},  32'd0);
    step();
    chk("single_fd_drop", {31'd0, fd},  32'd0);

    // back-to-back frames with valid held; data changes mid-frame
    data  = 8'hFF;
    valid = 1'b1;
    step();
    data = 8'h00;
    frame14("b2b_a", {4'b1011, 8'hFF, 2'b00});
    chk("b2b_a_fd", {31'd0, fd}, 32'd1);
    t1 = cyc;
    step();
    valid = 1'b0;
    frame14("b2b_b", {4'b1011, 8'h00, 2'b00});
    chk("b2b_b_fd", {31'd0, fd}, 32'd1);
    t2 = cyc;
    chk("b2b_period", t2 - t1, 32'd15);
    step();

    // data driven to a different value while busy is ignored
    data  = 8'h3C;
    valid = 1'b1;
    step();
    valid = 1'b0;
    data  = 8'hC3;
    frame14("hold", {4'b1011, 8'h3C, 2'b00});
    chk("hold_fd", {31'd0, fd}, 32'd1);
    step();

    // reset during the third payload bit aborts the frame
    data  = 8'hFF;
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("abort_pre_tx", {31'd0, tx}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_tx",    {31'd0, tx},    32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_busy",  {31'd0, busy},  32'd0);
    chk("abort_fd",    {31'd0, fd},    32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("abort_quiet_fd%0d", i), {31'd0, fd}, 32'd0);
      chk($sformatf("abort_quiet_tx%0d", i), {31'd0, tx}, 32'd0);
    end

    // clean frame after abort, looped into the detector
    data  = 8'h00;
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      logic [13:0] lv;
      lv = {4'b1011, 8'h00, 2'b00};
      chk($sformatf("loop_tx%0d", i),  {31'd0, tx},  {31'd0, lv[13-i]});
      chk($sformatf("loop_det%0d", i), {31'd0, det}, {31'd0, (i == 4)});
      step();
    end
    chk("loop_fd",  {31'd0, fd},  32'd1);
    chk("loop_det_end", {31'd0, det}, 32'd0);
    step();

    // parameter corner: DATA_W=1, GUARD=1, data=1
    valid1 = 1'b1;
    step();
    valid1 = 1'b0;
    v6 = 6'b101110;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("corner_tx%0d", i),   {31'd0, tx1},   {31'd0, v6[5-i]});
      chk($sformatf("corner_busy%0d", i), {31'd0, busy1}, 32'd1);
      chk($sformatf("corner_fd%0d", i),   {31'd0, fd1},   32'd0);
      step();
    end
    chk("corner_fd",    {31'd0, fd1},    32'd1);
    chk("corner_ready", {31'd0, ready1}, 32'd1);
    step();
    chk("corner_fd_drop", {31'd0, fd1},  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
